// File: rtl/modsub_pkg.sv
// Shared types and constants for the limb-serial modular subtractor.
// Holds the FSM state encoding, default sizes and the secp256k1 prime.
package modsub_pkg;

    localparam int MODSUB_WIDTH  = 256;
    localparam int MODSUB_LIMB_W = 64;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_ADD  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/modsub_limb_alu.sv
// Combinational limb adder/subtractor shared by the SUB and ADD phases.
// Ports: sub (1=a-b-cin, 0=a+b+cin), a, b, cin -> y, cout (carry or borrow).
module modsub_limb_alu #(
    parameter int LIMB_W = 64
) (
    input  logic              sub,
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] y,
    output logic              cout
);

    logic [LIMB_W:0] r;

    always_comb begin
        r = '0;
        unique case (1'b1)
            sub:  r = {1'b0, a} - {1'b0, b} - {{LIMB_W{1'b0}}, cin};
            !sub: r = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
        endcase
    end

    assign y    = r[LIMB_W-1:0];
    assign cout = r[LIMB_W];

endmodule

// File: rtl/modular_subtractor_256.sv
// Limb-serial (A - B) mod p: N borrow-chain cycles, then N conditional-add cycles.
// Ports: i_clk, i_rst (sync, high), i_start, A, B, p -> result, done;
// o_range_err (A>=p or B>=p) exists only when MODSUB_RANGE_CHECK_EN is defined.
module modular_subtractor_256
    import modsub_pkg::*;
#(
    parameter int WIDTH  = MODSUB_WIDTH,
    parameter int LIMB_W = MODSUB_LIMB_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] result,
    output logic             done
`ifdef MODSUB_RANGE_CHECK_EN
    ,
    output logic             o_range_err
`endif
);

    localparam int N  = WIDTH / LIMB_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q;
    logic [CW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, p_q, d_q;
    logic             cy_q, neg_q;

    logic              is_sub;
    logic [LIMB_W-1:0] op_a, op_b, alu_y;
    logic              alu_c;
    logic [WIDTH-1:0]  d_next, p_rot;

    assign is_sub = (state_q == ST_SUB);
    assign op_a   = is_sub ? a_q[LIMB_W-1:0] : d_q[LIMB_W-1:0];
    assign op_b   = is_sub ? b_q[LIMB_W-1:0]
                  : (neg_q ? p_q[LIMB_W-1:0] : '0);

    modsub_limb_alu #(.LIMB_W(LIMB_W)) u_alu (
        .sub  (is_sub),
        .a    (op_a),
        .b    (op_b),
        .cin  (cy_q),
        .y    (alu_y),
        .cout (alu_c)
    );

    // D is a shift register: each new limb enters at the top, so after N
    // cycles limb 0 sits back at the bottom. p rotates to stay aligned.
    assign d_next = (d_q >> LIMB_W) | (WIDTH'(alu_y) << (WIDTH - LIMB_W));
    assign p_rot  = (p_q >> LIMB_W) | (p_q << (WIDTH - LIMB_W));

`ifdef MODSUB_RANGE_CHECK_EN
    logic              ra_q, rb_q, rflag_q;
    logic [LIMB_W-1:0] ra_y, rb_y;
    logic              ra_c, rb_c;

    modsub_limb_alu #(.LIMB_W(LIMB_W)) u_rng_a (
        .sub  (1'b1),
        .a    (a_q[LIMB_W-1:0]),
        .b    (p_q[LIMB_W-1:0]),
        .cin  (ra_q),
        .y    (ra_y),
        .cout (ra_c)
    );

    modsub_limb_alu #(.LIMB_W(LIMB_W)) u_rng_b (
        .sub  (1'b1),
        .a    (b_q[LIMB_W-1:0]),
        .b    (p_q[LIMB_W-1:0]),
        .cin  (rb_q),
        .y    (rb_y),
        .cout (rb_c)
    );

    // No final borrow on X - p means X >= p.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ra_q        <= 1'b0;
            rb_q        <= 1'b0;
            rflag_q     <= 1'b0;
            o_range_err <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ra_q <= 1'b0;
                    rb_q <= 1'b0;
                end
                ST_SUB: begin
                    ra_q <= ra_c;
                    rb_q <= rb_c;
                    if (idx_q == LAST)
                        rflag_q <= ~ra_c | ~rb_c;
                end
                ST_ADD: begin
                    if (idx_q == LAST)
                        o_range_err <= rflag_q;
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            d_q     <= '0;
            cy_q    <= 1'b0;
            neg_q   <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        a_q     <= A;
                        b_q     <= B;
                        p_q     <= p;
                        cy_q    <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    d_q   <= d_next;
                    a_q   <= a_q >> LIMB_W;
                    b_q   <= b_q >> LIMB_W;
                    p_q   <= p_rot;
                    cy_q  <= alu_c;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        neg_q   <= alu_c;
                        cy_q    <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    d_q   <= d_next;
                    p_q   <= p_rot;
                    cy_q  <= alu_c;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        result  <= d_next;
                        done    <= 1'b1;
                        cy_q    <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modular_subtractor_256.sv
// Randomised and directed bench for modular_subtractor_256.
// Compares against a plain big-integer reference of (A - B) mod p.
module tb_modular_subtractor_256;

    localparam logic [255:0] P_K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] a_in = '0, b_in = '0, p_in = '0;
    logic [255:0] result;
    logic         done;
`ifdef MODSUB_RANGE_CHECK_EN
    logic         range_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modular_subtractor_256 dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .A       (a_in),
        .B       (b_in),
        .p       (p_in),
        .result  (result),
        .done    (done)
`ifdef MODSUB_RANGE_CHECK_EN
        ,
        .o_range_err (range_err)
`endif
    );

    function automatic logic [255:0] ref_model(
        input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        if (a >= b) return a - b;
        return a - b + m;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Starts one operation and counts edges until done (bounded).
    task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] m, output int lat);
        @(negedge clk);
        a_in = a; b_in = b; p_in = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic check_op(input string name, input logic [255:0] a,
                            input logic [255:0] b, input logic [255:0] m);
        int lat;
        logic [255:0] exp;
        exp = ref_model(a, b, m);
        run_op(a, b, m, lat);
        checks++;
        if (lat != 8 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s latency got=%0d done=%b want=8", name, lat, done);
        end
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL %s result got=%h want=%h", name, result, exp);
        end
`ifdef MODSUB_RANGE_CHECK_EN
        checks++;
        if (range_err !== ((a >= m) || (b >= m))) begin
            failures++;
            $display("FAIL %s range_err got=%b want=%b", name, range_err,
                     (a >= m) || (b >= m));
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width got=%b want=0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset got result=%h done=%b want 0/0", result, done);
        end
`ifdef MODSUB_RANGE_CHECK_EN
        checks++;
        if (range_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_range got=%b want=0", range_err);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed();
        check_op("a5_b3", 256'd5, 256'd3, P_K1);
        check_op("a3_b5", 256'd3, 256'd5, P_K1);
        check_op("a0_b1", 256'd0, 256'd1, P_K1);
        check_op("pm1_b0", P_K1 - 1, 256'd0, P_K1);
        check_op("pm1_pm1", P_K1 - 1, P_K1 - 1, P_K1);
        check_op("limb_borrow", {192'd0, 64'hFFFF_FFFF_FFFF_FFFF} + 1,
                 256'd1, P_K1);
`ifdef MODSUB_RANGE_CHECK_EN
        check_op("a_eq_p", P_K1, 256'd7, P_K1);
        check_op("b_eq_p", 256'd9, P_K1, P_K1);
`endif
    endtask

    task automatic test_random();
        logic [255:0] m, a, b;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) m = P_K1;
            else m = rand256() | 256'd3;
            a = rand256() % m;
            b = rand256() % m;
            check_op("random", a, b, m);
        end
    endtask

    task automatic test_operand_change();
        logic [255:0] exp;
        int ndone;
        exp = ref_model(256'd100, 256'd200, P_K1);
        @(negedge clk);
        a_in = 256'd100; b_in = 256'd200; p_in = P_K1; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (k < 8) begin
                a_in = rand256(); b_in = rand256(); p_in = rand256();
                start = k[0];
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                checks++;
                if (result !== exp) begin
                    failures++;
                    $display("FAIL latch result got=%h want=%h", result, exp);
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL latch_done_count got=%0d want=1", ndone);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        check_op("pre_reset", 256'd50, 256'd8, P_K1);
        @(negedge clk);
        a_in = 256'd1; b_in = 256'd2; p_in = P_K1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (result !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got result=%h done=%b want 0/0",
                     result, done);
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL mid_reset_no_done got=%0d want=0", ndone);
        end
        check_op("post_reset", 256'd1, 256'd2, P_K1);
    endtask

    task automatic test_back_to_back();
        logic [255:0] a, b, exp;
        int t_prev, seen;
        a = rand256() % P_K1;
        b = rand256() % P_K1;
        t_prev = -1;
        @(negedge clk);
        a_in = a; b_in = b; p_in = P_K1; start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            exp = ref_model(a, b, P_K1);
            seen = 0;
            for (int k = 0; k < 30; k++) begin
                @(posedge clk); #1;
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            checks++;
            if (seen == 0 || result !== exp) begin
                failures++;
                $display("FAIL b2b_result op=%0d seen=%0d got=%h want=%h",
                         op, seen, result, exp);
            end
            if (op > 0) begin
                checks++;
                if (cyc - t_prev != 10) begin
                    failures++;
                    $display("FAIL b2b_period got=%0d want=10", cyc - t_prev);
                end
            end
            t_prev = cyc;
            a = rand256() % P_K1;
            b = rand256() % P_K1;
            a_in = a; b_in = b;
            if (op == 2) start = 1'b0;
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got=%b want=0", done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_operand_change();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modular_subtractor_256.md
Name: modular_subtractor_256

Overview:
Multi-cycle modular subtractor computing result = (A − B) mod p for 256-bit operands, e.g. the secp256k1 field prime, as a field-arithmetic primitive in the elliptic-curve point-arithmetic datapath.
Limb-serial: one LIMB_W-bit limb per clock.
Phase 1 forms A − B with a borrow chain. Phase 2 conditionally adds p.
Start/done handshake; operands are latched at start.

Parameters:
WIDTH, 256, operand/result width in bits.
LIMB_W, 64, limb width processed per cycle; WIDTH % LIMB_W must be 0. N = WIDTH/LIMB_W (default 4).

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst  input  1  reset, synchronous, active-high.
i_start  input  1  request; sampled only in IDLE.
A  input  WIDTH  minuend; precondition A < p.
B  input  WIDTH  subtrahend; precondition B < p.
p  input  WIDTH  modulus; precondition p odd, p > 1.
result  output  WIDTH  (A − B) mod p, registered.
done  output  1  one-cycle completion pulse.

Behaviour:
- One clock (i_clk); reset is synchronous, active-high (i_rst).
- Reset (i_rst=1 at an edge): state=IDLE; result=0; done=0; internal registers cleared.
- Reset has priority over everything, including mid-operation: the operation is aborted, no done pulse, and the bench returns to IDLE next cycle.
- States: IDLE, SUB, ADD, FIN.
- IDLE:
  - on an edge with i_start=1, latch A, B, p into internal registers, clear borrow/carry and limb index, then go to SUB.
  - A, B, p may change after that edge without effect.
- SUB (N cycles), one limb per cycle, limb 0 first:
  - diff_k = A_k − B_k − borrow, computed LIMB_W+1 wide.
  - store the low LIMB_W bits in work register D.
  - borrow = bit LIMB_W of the difference.
  - after limb N−1, the final borrow is latched as neg; go to ADD.
- ADD (N cycles):
  - sum_k = D_k + (neg ? p_k : 0) + carry.
  - store the low LIMB_W bits in D; carry is discarded after the last limb.
  - ADD always runs N cycles, giving constant latency independent of data.
- On the edge completing limb N−1 of ADD: result ← D, done ← 1, go to FIN.
- FIN: one cycle; the next edge clears done and returns to IDLE.
- Latency: done is high during the cycle after the 2N-th edge following the sampling edge (8 edges at default). done is exactly one cycle wide.
- result holds its value until the next completion or reset.
- i_start during SUB/ADD/FIN is ignored. If i_start is held high continuously, a new operation starts on the first IDLE edge, i.e. back-to-back with a one-cycle IDLE gap.
- Arithmetic identity: result = A − B if A ≥ B, else A − B + p (mod 2^WIDTH). With the preconditions met, 0 ≤ result < p.
- Violated preconditions: output is the same formula computed modulo 2^WIDTH; no error is raised unless the optional feature is enabled.

Optional Feature:
MODSUB_RANGE_CHECK_EN:
- Defined: adds output o_range_err (1 bit). It is registered with done and set when latched A ≥ p or B ≥ p.
- The comparisons are done limb-serially during SUB using the two extra borrow chains A−p and B−p, so latency is unchanged. o_range_err resets to 0 and holds until the next completion.
- Not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package modsub_pkg:
  - state enum (IDLE, SUB, ADD, FIN).
  - default WIDTH/LIMB_W constants.
  - SECP256K1_P = FFFFFFFF…FFFFFFFEFFFFFC2F.
- One natural sub-module: modsub_limb_alu. It is a combinational LIMB_W-bit add/subtract with carry/borrow in and out, selected by a mode bit, and is shared by the SUB and ADD phases.

Test Plan:
- p=SECP256K1_P, A=5, B=3 -> result=2; done exactly 8 edges after start is sampled, one cycle wide.
- A=3, B=5 -> result=p−2=FF…FFFEFFFFFC2D.
- A=0, B=1 -> result=p−1=FF…FFFEFFFFFC2E; A=p−1, B=0 -> result=p−1; A=B=p−1 -> result=0.
- Change A/B during SUB/ADD, and pulse i_start while busy -> result reflects the operands latched at start; no extra done.
- Assert i_rst in the 3rd SUB cycle -> result=0, done=0, state IDLE. A fresh start then completes normally with the correct value.
- Hold i_start high for 3 operations -> a done pulse every 10 cycles, results all correct. With MODSUB_RANGE_CHECK_EN, A=p -> o_range_err=1 with done.
